// File: rtl/ftdi_tx_if.sv
// Byte-stream source, FTDI FT245-style TX bus and RX arbitration signals of ftdi_tx.
// master = the side feeding bytes and modelling the FTDI/RX peers; slave = ftdi_tx.
interface ftdi_tx_if #(
    parameter int DEPTH = 16
);
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    ftdi_txe_n;
    logic                    ftdi_wr_n;
    logic [7:0]              ftdi_data_out;
    logic                    ftdi_data_oe;
    logic                    rx_req;
    logic                    rx_grant;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic [15:0]             tx_count;

    modport master (
        output tx_data, tx_valid, ftdi_txe_n, rx_req,
        input  tx_ready, ftdi_wr_n, ftdi_data_out, ftdi_data_oe, rx_grant, fifo_level, tx_count
    );

    modport slave (
        input  tx_data, tx_valid, ftdi_txe_n, rx_req,
        output tx_ready, ftdi_wr_n, ftdi_data_out, ftdi_data_oe, rx_grant, fifo_level, tx_count
    );
endinterface

// File: rtl/ftdi_tx.sv
// TX FIFO plus FTDI synchronous-FIFO write sequencer sharing the data bus with a receive side.
// Bus turnaround is bracketed by DRIVE/RELEASE so the pads never fight the FTDI chip.
module ftdi_tx #(
    parameter int DEPTH = 16
) (
    input  logic       clk_60,
    input  logic       rst_n,
    ftdi_tx_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, WRITE, RELEASE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [15:0]     count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic            tx_ready;
    logic            push;
    logic            pop;

    assign tx_ready = (level_q < DEPTH_L);

    always_comb begin
        push     = bus.tx_valid && tx_ready;
        // WRITE is only ever held with data present, so txe_n alone gates the pop
        pop      = (state_q == WRITE) && !bus.ftdi_txe_n;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
        count_d  = count_q + 16'(pop);
        state_d  = state_q;
        case (state_q)
            IDLE: begin
                if (level_q != '0 && !bus.rx_req && !bus.ftdi_txe_n) state_d = DRIVE;
            end
            DRIVE: begin
                state_d = bus.rx_req ? RELEASE : WRITE;
            end
            WRITE: begin
                if (bus.ftdi_txe_n || bus.rx_req || level_d == '0) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_60) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes stale entries as valid.
    always_ff @(posedge clk_60) begin
        if (push) mem_q[wr_ptr_q] <= bus.tx_data;
    end

    assign bus.tx_ready      = tx_ready;
    assign bus.ftdi_wr_n     = (state_q != WRITE);
    assign bus.ftdi_data_oe  = (state_q == DRIVE) || (state_q == WRITE);
    assign bus.rx_grant      = (state_q == IDLE) && bus.rx_req;
    assign bus.ftdi_data_out = mem_q[rd_ptr_q];
    assign bus.fifo_level    = level_q;
    assign bus.tx_count      = count_q;
endmodule

// File: tb/tb_ftdi_tx.sv
// Bench for ftdi_tx: queue-based bus model checked every cycle, plus directed scenarios
// with literal expectations on latency, ordering, backpressure, arbitration, full, wrap and reset.
module tb_ftdi_tx;
    localparam int DEPTH = 16;
    localparam int M_IDLE = 0, M_DRIVE = 1, M_WRITE = 2, M_REL = 3;

    bit   clk_60 = 1'b0;
    logic rst_n;
    always #5 clk_60 = ~clk_60;

    ftdi_tx_if #(.DEPTH(DEPTH)) bus ();
    ftdi_tx #(.DEPTH(DEPTH)) dut (.clk_60(clk_60), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue, pop counter and bus phase following the written bus rules.
    logic [7:0] mq[$];
    int  mcnt = 0;
    int  ph   = M_IDLE;
    bit  started = 1'b0;
    bit  had, pu, po;
    logic [7:0] seen[$];

    always @(posedge clk_60) begin
        started = 1'b1;
        if (!rst_n) begin
            mq.delete();
            mcnt = 0;
            ph   = M_IDLE;
        end else begin
            had = (mq.size() != 0);
            po  = (ph == M_WRITE) && !bus.ftdi_txe_n;
            pu  = bus.tx_valid && (mq.size() < DEPTH);
            if (po) begin
                void'(mq.pop_front());
                mcnt = (mcnt + 1) % 65536;
            end
            if (pu) mq.push_back(bus.tx_data);
            case (ph)
                M_IDLE:  ph = (had && !bus.rx_req && !bus.ftdi_txe_n) ? M_DRIVE : M_IDLE;
                M_DRIVE: ph = bus.rx_req ? M_REL : M_WRITE;
                M_WRITE: ph = (!bus.ftdi_txe_n && !bus.rx_req && mq.size() != 0) ? M_WRITE : M_REL;
                default: ph = M_IDLE;
            endcase
        end
    end

    // Bytes the FTDI side actually takes off the bus, as seen on the pins.
    always @(posedge clk_60) begin
        if (rst_n === 1'b1 && bus.ftdi_wr_n === 1'b0 && bus.ftdi_txe_n === 1'b0)
            seen.push_back(bus.ftdi_data_out);
    end

    always @(negedge clk_60) begin
        if (started) begin
            chk("wr_n",     32'(bus.ftdi_wr_n),    32'(ph != M_WRITE));
            chk("data_oe",  32'(bus.ftdi_data_oe), 32'(ph == M_DRIVE || ph == M_WRITE));
            chk("rx_grant", 32'(bus.rx_grant),     32'(ph == M_IDLE && bus.rx_req));
            chk("level",    32'(bus.fifo_level),   32'(mq.size()));
            chk("tx_ready", 32'(bus.tx_ready),     32'(mq.size() < DEPTH));
            chk("tx_count", 32'(bus.tx_count),     32'(mcnt));
            if (mq.size() != 0) chk("data_out", 32'(bus.ftdi_data_out), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk_60);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit acc;
        int k;
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        k = 0;
        do begin
            acc = bus.tx_ready;
            tick();
            k++;
        end while (!acc && k < 200);
        if (!acc) chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bus.tx_valid = 1'b0;
        for (int k = 0; k < 300 && (bus.fifo_level != 0 || bus.ftdi_data_oe !== 1'b0); k++) tick();
        tick();
        tick();
        chk("drain_level", 32'(bus.fifo_level), 32'd0);
    endtask

    task automatic wait_seen(input int n);
        for (int k = 0; k < 100 && seen.size() < n; k++) tick();
        chk("wait_seen", 32'(seen.size()), 32'(n));
    endtask

    task automatic check_seq(input string name, input logic [7:0] base, input int n);
        chk({name, "_len"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++)
            chk({name, "_byte"}, 32'(seen[i]), 32'(base + 8'(i)));
        seen.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = 8'h00;
        bus.ftdi_txe_n = 1'b0;
        bus.rx_req     = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_wr_n",  32'(bus.ftdi_wr_n), 32'd1);
        chk("rst_oe",    32'(bus.ftdi_data_oe), 32'd0);
        chk("rst_count", 32'(bus.tx_count), 32'd0);
        bus.rx_req = 1'b1;
        #1;
        chk("rst_grant", 32'(bus.rx_grant), 32'd1);
        bus.rx_req = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single byte: push edge N, DRIVE N+1, wr_n low N+2, pop N+3, RELEASE then IDLE.
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h5A;
        tick();
        bus.tx_valid = 1'b0;
        chk("lat_n_level", 32'(bus.fifo_level), 32'd1);
        chk("lat_n_oe",    32'(bus.ftdi_data_oe), 32'd0);
        tick();
        chk("lat_n1_oe",   32'(bus.ftdi_data_oe), 32'd1);
        chk("lat_n1_wr_n", 32'(bus.ftdi_wr_n), 32'd1);
        tick();
        chk("lat_n2_wr_n", 32'(bus.ftdi_wr_n), 32'd0);
        chk("lat_n2_data", 32'(bus.ftdi_data_out), 32'h5A);
        tick();
        chk("lat_n3_count", 32'(bus.tx_count), 32'd1);
        chk("lat_n3_wr_n",  32'(bus.ftdi_wr_n), 32'd1);
        chk("lat_n3_oe",    32'(bus.ftdi_data_oe), 32'd0);
        tick();
        chk("lat_n4_oe",    32'(bus.ftdi_data_oe), 32'd0);
        check_seq("single", 8'h5A, 1);

        // Burst of 16 back-to-back.
        for (int i = 0; i < 16; i++) send(8'(i));
        drain();
        check_seq("burst", 8'h00, 16);
        chk("burst_count", 32'(bus.tx_count), 32'd17);

        // Backpressure after byte 4 of 8.
        bus.ftdi_txe_n = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
        bus.tx_valid = 1'b0;
        bus.ftdi_txe_n = 1'b0;
        wait_seen(4);
        bus.ftdi_txe_n = 1'b1;
        tick();
        chk("bp_level", 32'(bus.fifo_level), 32'd4);
        chk("bp_wr_n",  32'(bus.ftdi_wr_n), 32'd1);
        chk("bp_oe",    32'(bus.ftdi_data_oe), 32'd0);
        tick();
        tick();
        bus.ftdi_txe_n = 1'b0;
        drain();
        check_seq("backpressure", 8'h10, 8);
        chk("bp_count", 32'(bus.tx_count), 32'd25);

        // Arbitration mid-burst.
        bus.ftdi_txe_n = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        bus.tx_valid = 1'b0;
        bus.ftdi_txe_n = 1'b0;
        wait_seen(2);
        bus.rx_req = 1'b1;
        tick();
        chk("arb_rel_wr_n",  32'(bus.ftdi_wr_n), 32'd1);
        chk("arb_rel_oe",    32'(bus.ftdi_data_oe), 32'd0);
        chk("arb_rel_grant", 32'(bus.rx_grant), 32'd0);
        chk("arb_last_pop",  32'(seen.size()), 32'd3);
        tick();
        chk("arb_grant", 32'(bus.rx_grant), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("arb_hold_pops", 32'(seen.size()), 32'd3);
        chk("arb_hold_oe",   32'(bus.ftdi_data_oe), 32'd0);
        bus.rx_req = 1'b0;
        drain();
        check_seq("arbitration", 8'h20, 8);

        // Full FIFO: 17th byte held by the source until space appears.
        bus.ftdi_txe_n = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
        chk("full_level", 32'(bus.fifo_level), 32'd16);
        chk("full_ready", 32'(bus.tx_ready), 32'd0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h40;
        tick();
        tick();
        chk("full_hold_level", 32'(bus.fifo_level), 32'd16);
        bus.ftdi_txe_n = 1'b0;
        send(8'h40);
        drain();
        check_seq("full", 8'h30, 17);
        chk("full_count", 32'(bus.tx_count), 32'd50);

        // Reset in the middle of a burst.
        bus.ftdi_txe_n = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i));
        bus.tx_valid = 1'b0;
        bus.ftdi_txe_n = 1'b0;
        wait_seen(2);
        rst_n = 1'b0;
        tick();
        chk("mrst_wr_n",  32'(bus.ftdi_wr_n), 32'd1);
        chk("mrst_oe",    32'(bus.ftdi_data_oe), 32'd0);
        chk("mrst_level", 32'(bus.fifo_level), 32'd0);
        chk("mrst_count", 32'(bus.tx_count), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("mrst_no_pops", 32'(seen.size()), 32'd2);
        seen.delete();

        // Counter wrap: 65535 pops reach 0xFFFF, the next pop wraps to 0.
        for (int i = 0; i < 65535; i++) send(8'(i));
        drain();
        chk("wrap_ffff", 32'(bus.tx_count), 32'h0000FFFF);
        chk("wrap_seen", 32'(seen.size()), 32'd65535);
        seen.delete();
        send(8'hAA);
        drain();
        chk("wrap_zero", 32'(bus.tx_count), 32'd0);
        check_seq("wrap_byte", 8'hAA, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ftdi_tx.md
FTDI_TX -- requirements
Module: ftdi_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning TX FIFO depth in bytes; power of two, at least 4.
REQ-002 SHALL have port clk_60  in  1  the 60 MHz FTDI clock, the only clock.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port tx_data  in  8  byte to transmit to the host.
REQ-005 SHALL have port tx_valid  in  1  tx_data is valid.
REQ-006 SHALL have port tx_ready  out  1  FIFO can accept a byte.
REQ-007 SHALL have port ftdi_txe_n  in  1  high means the FTDI TX FIFO is full and cannot accept a write.
REQ-008 SHALL have port ftdi_wr_n  out  1  low means write the byte on the bus.
REQ-009 SHALL have port ftdi_data_out  out  8  byte driven onto the FTDI data bus.
REQ-010 SHALL have port ftdi_data_oe  out  1  pad output-enable for the bidirectional data bus.
REQ-011 SHALL have port rx_req  in  1  the receive side requests the bus.
REQ-012 SHALL have port rx_grant  out  1  the receive side may use the bus.
REQ-013 SHALL have port fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port tx_count  out  16  bytes accepted by the FTDI, wrapping.

Function
REQ-015 SHALL push tx_data into the FIFO on each rising edge where tx_valid && tx_ready.
REQ-016 SHALL drive tx_ready = (fifo_level < DEPTH); tx_valid while not ready SHALL be ignored without corrupting the FIFO.
REQ-017 SHALL drive ftdi_data_out from the FIFO head at all times, stable until that byte is consumed.
REQ-018 SHALL treat a byte as consumed (pop) exactly on a rising edge where state==WRITE and ftdi_txe_n==0.
REQ-019 SHALL support push and pop on the same edge; fifo_level is then unchanged.
REQ-020 SHALL implement FSM states IDLE, DRIVE, WRITE, RELEASE.
REQ-021 IDLE behaviour:
- ftdi_data_oe=0, ftdi_wr_n=1.
- rx_grant = rx_req (combinational).
- Next state is DRIVE when FIFO non-empty && rx_req==0 && ftdi_txe_n==0; otherwise stay in IDLE.
- rx_req takes priority over pending TX data.
REQ-022 DRIVE behaviour:
- ftdi_data_oe=1, ftdi_wr_n=1, rx_grant=0.
- Single bus-turnaround cycle.
- Next state is RELEASE if rx_req==1, else WRITE.
REQ-023 WRITE behaviour:
- ftdi_data_oe=1, ftdi_wr_n=0, rx_grant=0.
- Stays in WRITE only if all hold: ftdi_txe_n==0, rx_req==0, and the FIFO is non-empty after this edge's pop.
- Otherwise next state is RELEASE.
REQ-024 RELEASE behaviour:
- ftdi_data_oe=0, ftdi_wr_n=1, rx_grant=0.
- One dead cycle; next state is IDLE.
REQ-025 ftdi_wr_n and ftdi_data_oe SHALL be glitch-free decodes of the registered state only.
REQ-026 SHALL apply the following push-to-write latency: with FIFO empty in IDLE, ftdi_txe_n=0 and rx_req=0, a push at edge N gives DRIVE from edge N+1, ftdi_wr_n low from edge N+2, and the pop at edge N+3.
REQ-027 Back-to-back throughput SHALL be one byte per clk_60 while in WRITE with ftdi_txe_n low and the FIFO non-empty.
REQ-028 ftdi_txe_n rising during WRITE: no pop on that edge, the byte is retained, exit via RELEASE, and resume at the same byte when ftdi_txe_n is low again.
REQ-029 tx_count SHALL increment by 1 per pop, wrapping 65535 -> 0.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; a full FIFO SHALL reach fifo_level == DEPTH with no data loss.

Reset
REQ-031 On a clk_60 edge with rst_n low, the block SHALL set:
- state=IDLE, FIFO empty, fifo_level=0, tx_count=0;
- ftdi_wr_n=1, ftdi_data_oe=0, tx_ready=1;
- rx_grant=rx_req.
REQ-032 Reset mid-WRITE SHALL discard all FIFO contents and SHALL NOT pop; ftdi_wr_n SHALL be high from the first reset edge.
REQ-033 No outputs SHALL change asynchronously with rst_n.

Verification
REQ-034 Single-byte latency: push 0x5A with txe_n=0 and rx_req=0 -> ftdi_wr_n low at edge N+2 with data 0x5A, one pop, tx_count=1, then RELEASE, then IDLE.
REQ-035 Burst: push 16 bytes 0x00..0x0F back-to-back with txe_n=0 -> 16 consecutive pops in order, fifo_level ends at 0, tx_count=16.
REQ-036 Backpressure: txe_n high for 3 cycles after byte 4 of 8 -> exit via RELEASE, byte 4 not lost, all 8 bytes delivered in order exactly once.
REQ-037 Arbitration: rx_req asserted mid-burst -> WRITE exits, RELEASE for one cycle, IDLE with rx_grant=1; TX resumes only after rx_req falls.
REQ-038 Full and wrap: push 17 with DEPTH=16 and txe_n high -> tx_ready=0 at level 16, the 17th byte is held by the source; tx_count starting at 0xFFFF wraps to 0 on the next pop.
REQ-039 Reset mid-burst -> ftdi_wr_n=1, ftdi_data_oe=0, fifo_level=0 at the next edge, and no further pops.
